// File: rtl/parameters_pkg.sv
// Shared types, defaults and sizing helpers for the reset synchroniser/sequencer.
package parameters_pkg;

    // Sequencer states: wait for the deassertion synchroniser, hold, staggered release, idle.
    typedef enum logic [1:0] {
        SYNC = 2'd0,
        HOLD = 2'd1,
        REL  = 2'd2,
        DONE = 2'd3
    } rst_seq_state_t;

    // Default timing used by every clock domain unless overridden at instantiation.
    localparam int RST_SYNC_STAGES = 2;
    localparam int RST_HOLD_CYCLES = 4;
    localparam int RST_GAP_CYCLES  = 3;

    // Counter must be able to hold the larger of the hold and gap durations.
    function automatic int rst_cnt_width(input int hold_cycles, input int gap_cycles);
        int longest;
        longest = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/bit_sync_chain.sv
// Multi-flop synchroniser with asynchronous clear. Exposes the last stage and the
// stage feeding it so a consumer can register its own transition on the same edge
// the chain output rises.
module bit_sync_chain
    import parameters_pkg::*;
#(
    parameter int STAGES = RST_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic pre
);

    logic [STAGES-1:0] chain;

    // Shift the input through the chain; the whole chain clears the moment rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q   = chain[STAGES-1];
    assign pre = chain[STAGES-2];

endmodule

// File: rtl/rst_sync_seq.sv
// Reset synchroniser and sequencer: asynchronous assertion, synchronised deassertion,
// a minimum hold period, then NUM_OUT active-low resets released one by one with a
// fixed gap. A synchronous software request re-runs the hold/release sequence.
module rst_sync_seq
    import parameters_pkg::*;
#(
    parameter int SYNC_STAGES = RST_SYNC_STAGES,
    parameter int HOLD_CYCLES = RST_HOLD_CYCLES,
    parameter int GAP_CYCLES  = RST_GAP_CYCLES,
    parameter int NUM_OUT     = 3,
    parameter int SW_RST_EN   = 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               SW_RST_REQ,
    output logic [NUM_OUT-1:0] SYNC_RST,
    output logic               RST_DONE,
    output logic               RST_BUSY
);

    localparam int CNT_W = rst_cnt_width(HOLD_CYCLES, GAP_CYCLES);
    localparam int IDX_W = $clog2(NUM_OUT + 1);

    localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_OUT - 1);
    localparam logic [IDX_W-1:0]   IDX_ONE   = IDX_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [NUM_OUT-1:0] REL_BIT   = NUM_OUT'(1);

    // Illegal parameter values stop elaboration rather than producing a broken sequencer.
    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync_stages
            $error("rst_sync_seq: SYNC_STAGES must be >= 2");
        end
        if (HOLD_CYCLES < 1) begin : g_bad_hold_cycles
            $error("rst_sync_seq: HOLD_CYCLES must be >= 1");
        end
        if (GAP_CYCLES < 1) begin : g_bad_gap_cycles
            $error("rst_sync_seq: GAP_CYCLES must be >= 1");
        end
        if (NUM_OUT < 1) begin : g_bad_num_out
            $error("rst_sync_seq: NUM_OUT must be >= 1");
        end
    endgenerate

    rst_seq_state_t   state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             sync_out;
    logic             sync_pre;
    logic             sw_req;

    // Deassertion synchroniser: a constant 1 walks through the chain after RST falls.
    bit_sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (CLK),
        .rst (RST),
        .d   (1'b1),
        .q   (sync_out),
        .pre (sync_pre)
    );

    // Domains that must not be reset by software get the request tied off here.
    assign sw_req = (SW_RST_EN != 0) ? SW_RST_REQ : 1'b0;

    // Sequencer FSM with registered outputs. SYNC leaves on the edge the chain output
    // rises (decided from the stage feeding it), so HOLD starts counting on edge
    // SYNC_STAGES exactly as a software request starts it on its own edge. Releases
    // shift a 1 in from bit 0, which keeps SYNC_RST thermometer-coded by construction.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= SYNC;
            cnt      <= '0;
            idx      <= '0;
            SYNC_RST <= '0;
            RST_DONE <= 1'b0;
            RST_BUSY <= 1'b1;
        end else if (sw_req && (state != SYNC || sync_out)) begin
            state    <= HOLD;
            cnt      <= '0;
            idx      <= '0;
            SYNC_RST <= '0;
            RST_DONE <= 1'b0;
            RST_BUSY <= 1'b1;
        end else begin
            case (state)
                SYNC: begin
                    if (sync_pre) begin
                        state <= HOLD;
                        cnt   <= '0;
                        idx   <= '0;
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        SYNC_RST <= (SYNC_RST << 1) | REL_BIT;
                        cnt      <= '0;
                        if (NUM_OUT == 1) begin
                            state    <= DONE;
                            idx      <= '0;
                            RST_DONE <= 1'b1;
                            RST_BUSY <= 1'b0;
                        end else begin
                            state <= REL;
                            idx   <= IDX_ONE;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                REL: begin
                    if (cnt == GAP_LAST) begin
                        SYNC_RST <= (SYNC_RST << 1) | REL_BIT;
                        cnt      <= '0;
                        if (idx == LAST_IDX) begin
                            state    <= DONE;
                            idx      <= '0;
                            RST_DONE <= 1'b1;
                            RST_BUSY <= 1'b0;
                        end else begin
                            idx <= idx + IDX_ONE;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                DONE: begin
                    cnt <= '0;
                    idx <= '0;
                end
                default: begin
                    state    <= SYNC;
                    cnt      <= '0;
                    idx      <= '0;
                    SYNC_RST <= '0;
                    RST_DONE <= 1'b0;
                    RST_BUSY <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_sync_seq.sv
// Bench for rst_sync_seq: three instances (default, software reset disabled, and a
// minimal 3/1/1/1 configuration) share clock, reset and request. Expected outputs come
// from release-edge arithmetic: channel i of an instance is released once the edge count
// since RST fell reaches start + HOLD + i*GAP, where start is SYNC_STAGES after reset or
// the edge of the latest honoured software request.
module tb_rst_sync_seq;

    logic       clk;
    logic       rst;
    logic       sw_req;
    logic [2:0] sync_a;
    logic [2:0] sync_b;
    logic [0:0] sync_c;
    logic       done_a, busy_a, done_b, busy_b, done_c, busy_c;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int n = 0;
    int start [3];
    int prm_s  [3] = '{2, 2, 3};
    int prm_h  [3] = '{4, 4, 1};
    int prm_g  [3] = '{3, 3, 1};
    int prm_n  [3] = '{3, 3, 1};
    int prm_en [3] = '{1, 0, 1};

    rst_sync_seq #(.SYNC_STAGES(2), .HOLD_CYCLES(4), .GAP_CYCLES(3), .NUM_OUT(3), .SW_RST_EN(1)) dut_a (
        .CLK(clk), .RST(rst), .SW_RST_REQ(sw_req), .SYNC_RST(sync_a), .RST_DONE(done_a), .RST_BUSY(busy_a));

    rst_sync_seq #(.SYNC_STAGES(2), .HOLD_CYCLES(4), .GAP_CYCLES(3), .NUM_OUT(3), .SW_RST_EN(0)) dut_b (
        .CLK(clk), .RST(rst), .SW_RST_REQ(sw_req), .SYNC_RST(sync_b), .RST_DONE(done_b), .RST_BUSY(busy_b));

    rst_sync_seq #(.SYNC_STAGES(3), .HOLD_CYCLES(1), .GAP_CYCLES(1), .NUM_OUT(1), .SW_RST_EN(1)) dut_c (
        .CLK(clk), .RST(rst), .SW_RST_REQ(sw_req), .SYNC_RST(sync_c), .RST_DONE(done_c), .RST_BUSY(busy_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t, edge %0d)", tag, got, exp, $time, n);
        end
    endtask

    function automatic logic [31:0] exp_vec(input int k);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < prm_n[k]; i++) begin
            if (rst == 1'b0 && n >= start[k] + prm_h[k] + i * prm_g[k]) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [31:0] full_mask(input int k);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < prm_n[k]; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] get_sync(input int k);
        case (k)
            0:       return {29'b0, sync_a};
            1:       return {29'b0, sync_b};
            default: return {31'b0, sync_c};
        endcase
    endfunction

    function automatic logic get_done(input int k);
        case (k)
            0:       return done_a;
            1:       return done_b;
            default: return done_c;
        endcase
    endfunction

    function automatic logic get_busy(input int k);
        case (k)
            0:       return busy_a;
            1:       return busy_b;
            default: return busy_c;
        endcase
    endfunction

    function automatic logic is_thermo(input logic [31:0] v);
        return ((v + 32'd1) & v) == 32'd0;
    endfunction

    task automatic check_all();
        logic [31:0] e;
        for (int k = 0; k < 3; k++) begin
            e = exp_vec(k);
            check_val($sformatf("sync_rst[%0d]", k), get_sync(k), e);
            check_val($sformatf("rst_done[%0d]", k), {31'b0, get_done(k)}, {31'b0, e == full_mask(k)});
            check_val($sformatf("rst_busy[%0d]", k), {31'b0, get_busy(k)}, {31'b0, e != full_mask(k)});
            check_val($sformatf("thermo[%0d]", k), {31'b0, is_thermo(get_sync(k))}, 32'd1);
        end
    endtask

    task automatic model_reset();
        n = 0;
        for (int k = 0; k < 3; k++) start[k] = prm_s[k];
    endtask

    // One clock: drive request, take the edge, advance the model, check #1 later.
    task automatic tick(input logic req);
        sw_req = req;
        @(posedge clk);
        if (rst == 1'b0) begin
            n++;
            for (int k = 0; k < 3; k++) begin
                if (req && prm_en[k] != 0 && n >= prm_s[k] + 1) start[k] = n;
            end
        end
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic run_to(input int m);
        int guard;
        guard = 0;
        while (n < m && guard < 200) begin
            tick(1'b0);
            guard++;
        end
        check_val("run_to_edge", n, m);
    endtask

    task automatic expect_a(input string tag, input logic [2:0] v);
        check_val(tag, {29'b0, sync_a}, {29'b0, v});
    endtask

    // Directed power-on style timeline, counted from the current RST fall.
    task automatic timeline(input string pfx);
        run_to(3);  check_val({pfx, "_c_e3"}, {31'b0, sync_c}, 32'd0);
        run_to(4);  check_val({pfx, "_c_e4"}, {31'b0, sync_c}, 32'd1);
        check_val({pfx, "_c_done_e4"}, {31'b0, done_c}, 32'd1);
        run_to(5);  expect_a({pfx, "_a_e5"}, 3'b000);
        run_to(6);  expect_a({pfx, "_a_e6"}, 3'b001);
        run_to(8);  expect_a({pfx, "_a_e8"}, 3'b001);
        run_to(9);  expect_a({pfx, "_a_e9"}, 3'b011);
        run_to(11); expect_a({pfx, "_a_e11"}, 3'b011);
        check_val({pfx, "_a_done_e11"}, {31'b0, done_a}, 32'd0);
        run_to(12); expect_a({pfx, "_a_e12"}, 3'b111);
        check_val({pfx, "_a_done_e12"}, {31'b0, done_a}, 32'd1);
        check_val({pfx, "_a_busy_e12"}, {31'b0, busy_a}, 32'd0);
    endtask

    initial begin
        int r;
        sw_req = 1'b0;
        rst    = 1'b1;
        model_reset();

        // Power-on: RST high for 3 cycles, released between edges.
        repeat (3) tick(1'b0);
        rst = 1'b0;
        model_reset();
        timeline("pwr");

        // Single software request sampled at edge 20.
        run_to(19);
        tick(1'b1);
        expect_a("sw_a_e20", 3'b000);
        check_val("sw_b_e20", {29'b0, sync_b}, 32'h7);
        check_val("sw_c_e20", {31'b0, sync_c}, 32'd0);
        run_to(21); check_val("sw_c_e21", {31'b0, sync_c}, 32'd1);
        run_to(23); expect_a("sw_a_e23", 3'b000);
        run_to(24); expect_a("sw_a_e24", 3'b001);
        run_to(26); expect_a("sw_a_e26", 3'b001);
        run_to(27); expect_a("sw_a_e27", 3'b011);
        run_to(30); expect_a("sw_a_e30", 3'b111);

        // Glitch: 3 ns pulse between edges, asynchronous clear seen without a clock.
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        expect_a("glitch_a_async", 3'b000);
        #2;
        rst = 1'b0;
        timeline("glitch");

        // Held software request on edges 20..24.
        run_to(19);
        repeat (5) tick(1'b1);
        expect_a("held_a_e24", 3'b000);
        run_to(27); expect_a("held_a_e27", 3'b000);
        run_to(28); expect_a("held_a_e28", 3'b001);
        run_to(31); expect_a("held_a_e31", 3'b011);
        run_to(34); expect_a("held_a_e34", 3'b111);
        check_val("held_b_e34", {29'b0, sync_b}, 32'h7);

        // Mid-sequence reset between edges 10 and 11.
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        tick(1'b0);
        rst = 1'b0;
        run_to(10);
        expect_a("mid_a_e10", 3'b011);
        rst = 1'b1;
        model_reset();
        #1;
        expect_a("mid_a_async", 3'b000);
        check_val("mid_a_busy_async", {31'b0, busy_a}, 32'd1);
        check_all();
        tick(1'b0);
        rst = 1'b0;
        timeline("mid");

        // Randomised mix of software requests, glitches and multi-cycle resets.
        for (int it = 0; it < 800; it++) begin
            r = int'($urandom_range(0, 79));
            if (r == 0) begin
                rst = 1'b1;
                model_reset();
                #1;
                check_all();
                #2;
                rst = 1'b0;
            end else if (r == 1) begin
                rst = 1'b1;
                model_reset();
                #1;
                check_all();
                repeat ($urandom_range(1, 3)) tick(1'($urandom_range(0, 1)));
                rst = 1'b0;
            end
            tick($urandom_range(0, 11) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
